// File: rtl/bus_addr_decoder.sv
// Address decoder and read-return mux for a data memory plus NSLV peripheral windows.
// Zero-wait writes, RD_LAT+1 cycle reads; optional write protection under DECODER_WP_EN.
module bus_addr_decoder #(
  parameter int          AW            = 32,
  parameter int          DW            = 32,
  parameter int          NSLV          = 2,
  parameter int          MEM_AW        = 8,
  parameter logic [31:0] PERIPH_BASE   = 32'h0000_0800,
  parameter logic [31:0] PERIPH_STRIDE = 32'h0000_0100,
  parameter int          PERIPH_AW     = 4,
  parameter int          RD_LAT        = 1,
  localparam int         SELW          = $clog2(NSLV + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [AW-1:0]          addr,
  input  logic [(NSLV+1)*DW-1:0] rdata_bus,
`ifdef DECODER_WP_EN
  input  logic [NSLV:0]          wp_mask,
`endif
  output logic                   wem,
  output logic [NSLV-1:0]        we_per,
  output logic [SELW-1:0]        rdsel,
  output logic [DW-1:0]          rdata,
  output logic                   ready,
  output logic                   err,
  output logic [AW-1:0]          err_addr,
  input  logic                   err_clr
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cnt;
  logic [SELW-1:0] r_rdsel;
  logic            r_err;
  logic [AW-1:0]   r_err_addr;

  logic [NSLV-1:0] w_phit;
  logic            w_mem_hit;
  logic [SELW-1:0] w_sel;
  logic            w_accept;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_wp_blk;
  logic            w_miss;
  logic            w_rd_done;
  logic [DW-1:0]   w_rd_slice;

  // Peripheral window tags, computed at elaboration from base and stride.
  for (genvar k = 0; k < NSLV; k++) begin : g_phit
    localparam logic [AW-1:0] BASE = AW'(PERIPH_BASE) + AW'(k) * AW'(PERIPH_STRIDE);
    localparam logic [AW-1:0] TAG  = BASE >> PERIPH_AW;
    assign w_phit[k] = (addr[AW-1:PERIPH_AW] == TAG[AW-PERIPH_AW-1:0]);
  end

  assign w_mem_hit = (addr[AW-1:MEM_AW] == '0);

  // Descending scan so the lowest-numbered hit wins; memory beats all peripherals.
  always_comb begin
    w_sel = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (w_phit[k]) w_sel = SELW'(k + 2);
    end
    if (w_mem_hit) w_sel = SELW'(1);
  end

`ifdef DECODER_WP_EN
  always_comb begin
    w_wp_blk = 1'b0;
    for (int k = 0; k <= NSLV; k++) begin
      if (w_sel == SELW'(k + 1) && wp_mask[k]) w_wp_blk = we;
    end
  end
`else
  assign w_wp_blk = 1'b0;
`endif

  // rst_n gating keeps the combinational outputs quiet while reset is held.
  assign w_accept  = rst_n && (r_state == IDLE) && req;
  assign w_wr_acc  = w_accept && we;
  assign w_rd_acc  = w_accept && !we;
  assign w_miss    = w_accept && ((w_sel == '0) || w_wp_blk);
  assign w_rd_done = rst_n && (r_state == RD_WAIT) && (r_cnt == 3'd0);

  always_comb begin
    wem    = 1'b0;
    we_per = '0;
    if (w_wr_acc && !w_wp_blk) begin
      if (w_sel == SELW'(1)) wem = 1'b1;
      for (int k = 0; k < NSLV; k++) begin
        if (w_sel == SELW'(k + 2)) we_per[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_slice = '0;
    for (int k = 0; k <= NSLV; k++) begin
      if (r_rdsel == SELW'(k + 1)) w_rd_slice = rdata_bus[k*DW +: DW];
    end
  end

  assign ready = w_wr_acc || w_rd_done;
  assign rdata = w_rd_done ? w_rd_slice : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rd_acc) w_state_nxt = RD_WAIT;
      RD_WAIT: if (r_cnt == 3'd0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_rdsel <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_acc) begin
        r_rdsel <= w_sel;
        r_cnt   <= 3'(RD_LAT);
      end else if (r_state == RD_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // A fresh miss overrides a same-cycle clear so its address is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_miss && (!r_err || err_clr)) begin
      r_err      <= 1'b1;
      r_err_addr <= addr;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end
  end

  assign rdsel    = r_rdsel;
  assign err      = r_err;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench for bus_addr_decoder with a transaction-level reference model.
module tb_bus_addr_decoder;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          NSLV   = 2;
  localparam int          MEM_AW = 8;
  localparam logic [31:0] PB     = 32'h0000_0800;
  localparam logic [31:0] PS     = 32'h0000_0100;
  localparam int          PAW    = 4;
  localparam int          RD_LAT = 1;
  localparam int          SELW   = $clog2(NSLV + 2);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req;
  logic                   we;
  logic [AW-1:0]          addr;
  logic [(NSLV+1)*DW-1:0] rdata_bus;
  logic                   wem;
  logic [NSLV-1:0]        we_per;
  logic [SELW-1:0]        rdsel;
  logic [DW-1:0]          rdata;
  logic                   ready;
  logic                   err;
  logic [AW-1:0]          err_addr;
  logic                   err_clr;

  int total = 0;
  int bad   = 0;

  bus_addr_decoder #(
    .AW(AW), .DW(DW), .NSLV(NSLV), .MEM_AW(MEM_AW), .PERIPH_BASE(PB),
    .PERIPH_STRIDE(PS), .PERIPH_AW(PAW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .rdata_bus(rdata_bus),
`ifdef DECODER_WP_EN
    .wp_mask('0),
`endif
    .wem(wem), .we_per(we_per), .rdsel(rdsel), .rdata(rdata), .ready(ready),
    .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Region lookup from address ranges: 1=memory, k+2=peripheral k, 0=unmapped.
  function automatic int region(input logic [31:0] a);
    logic [31:0] base;
    if (a < (32'd1 << MEM_AW)) return 1;
    for (int k = 0; k < NSLV; k++) begin
      base = PB + k * PS;
      if (a >= base && a < base + (32'd1 << PAW)) return k + 2;
    end
    return 0;
  endfunction

  int          cyc = 0;
  bit          m_busy = 0;
  int          m_done = 0;
  int          m_sel = 0;
  bit          m_err = 0;
  logic [31:0] m_ea = '0;

  always @(negedge clk) begin
    logic          e_wem, e_ready, acc;
    logic [1:0]    e_wper;
    logic [DW-1:0] e_rdata;
    int            r;
    cyc++;
    e_wem = 0; e_ready = 0; e_wper = '0; e_rdata = '0;
    r = region(addr);
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_err = 0; m_ea = '0;
    end else begin
      if (!m_busy && req && we) begin
        e_ready = 1;
        if (r == 1) e_wem = 1;
        else if (r >= 2) e_wper[r-2] = 1'b1;
      end
      if (m_busy && cyc == m_done) begin
        e_ready = 1;
        if (m_sel != 0) e_rdata = rdata_bus[(m_sel-1)*DW +: DW];
      end
    end
    chk("m_wem", wem, e_wem);
    chk("m_we_per", we_per, e_wper);
    chk("m_ready", ready, e_ready);
    chk("m_rdata", rdata, e_rdata);
    chk("m_rdsel", rdsel, m_sel);
    chk("m_err", err, m_err);
    chk("m_err_addr", err_addr, m_ea);
    if (rst_n) begin
      acc = !m_busy && req;
      if (m_busy && cyc == m_done) m_busy = 0;
      if (acc && !we) begin
        m_busy = 1; m_done = cyc + RD_LAT + 1; m_sel = r;
      end
      if (acc && r == 0 && (!m_err || err_clr)) begin
        m_err = 1; m_ea = addr;
      end else if (err_clr) begin
        m_err = 0; m_ea = '0;
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a);
    @(posedge clk); #1;
    req = r; we = w; addr = a;
  endtask

  initial begin
    rst_n = 0; req = 0; we = 0; addr = '0; err_clr = 0;
    rdata_bus = {32'h2222_0002, 32'hCAFE_0001, 32'h1111_0000};
    @(negedge clk);
    chk("rst_rdsel", rdsel, 0); chk("rst_err", err, 0); chk("rst_ready", ready, 0);
    @(posedge clk); #1 rst_n = 1;

    drive(1, 1, 32'h10);  @(negedge clk);
    chk("wr_mem_wem", wem, 1); chk("wr_mem_per", we_per, 0); chk("wr_mem_rdy", ready, 1);
    drive(1, 1, 32'h904); @(negedge clk);
    chk("wr_p1_per", we_per, 2'b10); chk("wr_p1_wem", wem, 0); chk("wr_p1_rdy", ready, 1);
    drive(1, 1, 32'h804); @(negedge clk);
    chk("wr_p0_per", we_per, 2'b01); chk("wr_p0_rdy", ready, 1);
    drive(0, 0, 0);       @(negedge clk);
    chk("wr_err", err, 0);

    drive(1, 0, 32'h808); @(negedge clk);
    chk("rd_acc_rdy", ready, 0);
    drive(1, 1, 32'h10);  @(negedge clk);
    chk("rd_wait_sel", rdsel, 2); chk("rd_wait_rdy", ready, 0); chk("rd_wait_wem", wem, 0);
    drive(0, 0, 0);       @(negedge clk);
    chk("rd_done_rdy", ready, 1); chk("rd_done_dat", rdata, 32'hCAFE_0001);
    drive(0, 0, 0);       @(negedge clk);
    chk("rd_after_rdy", ready, 0); chk("rd_after_dat", rdata, 0);

    drive(1, 0, 32'hA00); @(negedge clk);
    drive(0, 0, 0);       @(negedge clk);
    chk("miss_sel", rdsel, 0); chk("miss_err", err, 1); chk("miss_ea", err_addr, 32'hA00);
    drive(0, 0, 0);       @(negedge clk);
    chk("miss_rdy", ready, 1); chk("miss_dat", rdata, 0);
    drive(1, 1, 32'h1000); @(negedge clk);
    chk("miss2_rdy", ready, 1); chk("miss2_wem", wem, 0);
    drive(0, 0, 0);       @(negedge clk);
    chk("miss2_ea", err_addr, 32'hA00);
    drive(1, 1, 32'h2000); err_clr = 1; @(negedge clk);
    drive(0, 0, 0); err_clr = 0; @(negedge clk);
    chk("clr_set_err", err, 1); chk("clr_set_ea", err_addr, 32'h2000);
    drive(0, 0, 0); err_clr = 1; @(negedge clk);
    drive(0, 0, 0); err_clr = 0; @(negedge clk);
    chk("clr_err", err, 0); chk("clr_ea", err_addr, 0);

    drive(1, 1, 32'h3000); @(negedge clk);
    drive(1, 0, 32'h4);    @(negedge clk);
    @(posedge clk); #1 req = 0; rst_n = 0;
    @(negedge clk);
    chk("rstrd_rdy", ready, 0); chk("rstrd_sel", rdsel, 0); chk("rstrd_err", err, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstrd_rdy2", ready, 0); chk("rstrd_dat", rdata, 0);
    @(posedge clk); #1 rst_n = 1;
    drive(1, 1, 32'h0); @(negedge clk);
    chk("post_wem", wem, 1); chk("post_rdy", ready, 1);
    drive(0, 0, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
